screen_sequencer: RTL and testbench
===================================

# screen_sequencer

Parametrised screen-selection controller between the per-screen pixel generators (menu, N game modes, result screens) and the VGA output stage. It tracks the game flow (menu → game mode k → result → menu) in an explicit state machine and registers the chosen pixel onto `color_out`. Screen changes are applied only on frame boundaries, so no frame ever mixes two screens. A result screen is held for a programmable number of frames, then the block returns to the menu on its own.

## Interface
Parameters:
- `COLOR_W`, 12, bits per pixel (RGB444 by default).
- `N_MODES`, 2, number of game modes (1..8).
- `HOLD_FRAMES`, 180, frames a result screen is shown before auto-return to menu. 0 means hold until `menu_req`.

Ports:
- `clk25`  in  1  pixel clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `disp_ena`  in  1  active video region.
- `frame_start`  in  1  one-cycle pulse at the start of each frame (first blanking line).
- `menu_req`  in  1  pulse: return to menu.
- `play_req`  in  N_MODES  pulse per mode: start mode k.
- `result_code`  in  2*N_MODES  per mode, bits [2k+1:2k]. 0 = game running; 1..3 = index of the result screen to show.
- `menu_pix`  in  COLOR_W  menu screen pixel.
- `game_pix`  in  N_MODES*COLOR_W  game pixel for mode k, bits [k*COLOR_W +: COLOR_W].
- `result_pix`  in  3*COLOR_W  result screens 1..3; screen r is at bits [(r-1)*COLOR_W +: COLOR_W].
- `color_out`  out  COLOR_W  registered output pixel.
- `mode_active`  out  N_MODES  one-hot running mode; all zero unless in PLAY.
- `screen_state`  out  2  encoding: 0 MENU, 1 PLAY, 2 RESULT.

## Operation
- **States:** MENU, PLAY, RESULT.
- **Internal registers:** `mode_idx`, `res_code` (2 bits), hold counter (width $clog2(HOLD_FRAMES+1)), `menu_pend`, `play_pend` (N_MODES bits).
- **Request capture:**
  - `menu_req` sets `menu_pend` in every state.
  - `play_req` bits are OR-ed into `play_pend` only in MENU and are ignored elsewhere.
  - A request arriving in the same cycle as `frame_start` takes effect at that `frame_start`.
- **All transitions happen only in a cycle where `frame_start` = 1.** Both pending registers are cleared at every `frame_start`, whether or not a transition occurs.
- **MENU:** if any `play_pend` bit is set, go to PLAY with `mode_idx` = lowest set index. `menu_pend` in MENU does nothing.
- **PLAY:** checks in priority order:
  - `menu_pend` → MENU.
  - Otherwise, `result_code[mode_idx]` ≠ 0 → RESULT. Latch it into `res_code` and load the counter with HOLD_FRAMES.
  - Other modes' result codes are ignored.
- **RESULT:** checks in priority order:
  - `menu_pend` → MENU.
  - Otherwise, if HOLD_FRAMES > 0: when counter = 1, go to MENU; else decrement.
  - With HOLD_FRAMES = 0 the counter is unused and the block stays in RESULT.
- **Pixel select:** MENU → `menu_pix`; PLAY → `game_pix[mode_idx]`; RESULT → `result_pix[res_code]`.
- **Output:** `color_out` is registered every cycle as `disp_ena ? selected : 0`.
- **Reset (async, any time, including mid-frame):**
  - State = MENU.
  - `color_out` = 0, `mode_active` = 0, `screen_state` = 0.
  - Pending registers, `mode_idx`, `res_code` and counter all cleared.
  - After reset release, the output starts from MENU on the next `clk25` edge.

## Timing
- **Pixel latency:** 1 cycle from `disp_ena` / pixel inputs to `color_out`.
- **State update:** the state changes on the `clk25` edge that samples `frame_start` = 1.
  - `screen_state` and `mode_active` reflect the new state in the next cycle.
  - `color_out` shows the new screen one cycle after that.
- **Request timing:** a request made k cycles before `frame_start` is honoured at that `frame_start`. No minimum pulse width beyond one cycle.
- **Result hold:** a RESULT entered at frame F returns to MENU at frame F + HOLD_FRAMES.

## Test plan
1. **Reset output:** `reset_n` = 0, then release; `disp_ena` = 1, `menu_pix` = 12'hF00 → `color_out` = 12'hF00 one cycle later, `screen_state` = 0, `mode_active` = 0.
2. **Frame-synced start:** in MENU, pulse `play_req` = 2'b10 mid-frame → no change until `frame_start`. Then `screen_state` = 1, `mode_active` = 2'b10, and `color_out` follows `game_pix[1]` = 12'h0F0.
3. **Simultaneous requests:** `play_req` = 2'b11 in the same cycle as `frame_start` → mode 0 selected in that frame.
4. **Result and auto-return:** HOLD_FRAMES = 3; in PLAY mode 0 set `result_code[1:0]` = 2 → `color_out` = `result_pix` screen 2 for exactly 3 frames, then MENU. A nonzero `result_code[3:2]` during this run has no effect.
5. **Menu priority over result:** in PLAY, `menu_req` and a nonzero result code both present at the same `frame_start` → MENU, not RESULT.
6. **Blanking and async reset:** `disp_ena` = 0 → `color_out` = 0 in all states. Assert `reset_n` mid-line while in RESULT → `color_out` = 0 immediately, without waiting for a clock edge, and state = MENU.

Source files
------------

// File: rtl/screen_sequencer.sv
// Screen-selection controller: tracks menu -> game mode -> result -> menu flow,
// switches screens only on frame boundaries and registers the chosen pixel.
module screen_sequencer #(
  parameter int COLOR_W     = 12,
  parameter int N_MODES     = 2,
  parameter int HOLD_FRAMES = 180
) (
  input  logic                       clk25,
  input  logic                       reset_n,
  input  logic                       disp_ena,
  input  logic                       frame_start,
  input  logic                       menu_req,
  input  logic [N_MODES-1:0]         play_req,
  input  logic [2*N_MODES-1:0]       result_code,
  input  logic [COLOR_W-1:0]         menu_pix,
  input  logic [N_MODES*COLOR_W-1:0] game_pix,
  input  logic [3*COLOR_W-1:0]       result_pix,
  output logic [COLOR_W-1:0]         color_out,
  output logic [N_MODES-1:0]         mode_active,
  output logic [1:0]                 screen_state
);

  localparam int MODE_W = (N_MODES > 1) ? $clog2(N_MODES) : 1;
  localparam int CNT_W  = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  typedef enum logic [1:0] {
    MENU   = 2'd0,
    PLAY   = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [MODE_W-1:0]    mode_idx, mode_idx_nxt;
  logic [1:0]           res_code, res_code_nxt;
  logic [CNT_W-1:0]     hold_cnt, hold_cnt_nxt;
  logic                 menu_pend, menu_pend_nxt;
  logic [N_MODES-1:0]   play_pend, play_pend_nxt;

  logic                 menu_any;
  logic [N_MODES-1:0]   play_any;
  logic [MODE_W-1:0]    play_low;
  logic                 play_found;
  logic [1:0]           cur_result;
  logic [COLOR_W-1:0]   pix_sel;

  // Requests in the frame_start cycle itself are merged with the pending bits.
  always_comb begin
    menu_any   = menu_pend | menu_req;
    play_any   = play_pend | ((state == MENU) ? play_req : '0);
    play_low   = '0;
    play_found = 1'b0;
    cur_result = 2'd0;
    for (int unsigned i = 0; i < N_MODES; i++) begin
      if (play_any[i] && !play_found) begin
        play_low   = MODE_W'(i);
        play_found = 1'b1;
      end
      if (mode_idx == MODE_W'(i))
        cur_result = result_code[2*i +: 2];
    end
  end

  always_comb begin
    state_nxt     = state;
    mode_idx_nxt  = mode_idx;
    res_code_nxt  = res_code;
    hold_cnt_nxt  = hold_cnt;
    menu_pend_nxt = menu_any;
    play_pend_nxt = play_any;
    if (frame_start) begin
      menu_pend_nxt = 1'b0;
      play_pend_nxt = '0;
      unique case (state)
        MENU: begin
          if (|play_any) begin
            state_nxt    = PLAY;
            mode_idx_nxt = play_low;
          end
        end
        PLAY: begin
          if (menu_any) begin
            state_nxt = MENU;
          end else if (cur_result != 2'd0) begin
            state_nxt    = RESULT;
            res_code_nxt = cur_result;
            hold_cnt_nxt = CNT_W'(HOLD_FRAMES);
          end
        end
        RESULT: begin
          if (menu_any) begin
            state_nxt = MENU;
          end else if (HOLD_FRAMES > 0) begin
            if (hold_cnt == CNT_W'(1))
              state_nxt = MENU;
            else
              hold_cnt_nxt = hold_cnt - CNT_W'(1);
          end
        end
        default: state_nxt = MENU;
      endcase
    end
  end

  always_comb begin
    pix_sel = menu_pix;
    case (state)
      PLAY: begin
        pix_sel = '0;
        for (int unsigned i = 0; i < N_MODES; i++)
          if (mode_idx == MODE_W'(i))
            pix_sel = game_pix[i*COLOR_W +: COLOR_W];
      end
      RESULT: begin
        pix_sel = '0;
        for (int unsigned r = 1; r <= 3; r++)
          if (res_code == 2'(r))
            pix_sel = result_pix[(r-1)*COLOR_W +: COLOR_W];
      end
      default: pix_sel = menu_pix;
    endcase
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= MENU;
      mode_idx  <= '0;
      res_code  <= '0;
      hold_cnt  <= '0;
      menu_pend <= 1'b0;
      play_pend <= '0;
      color_out <= '0;
    end else begin
      state     <= state_nxt;
      mode_idx  <= mode_idx_nxt;
      res_code  <= res_code_nxt;
      hold_cnt  <= hold_cnt_nxt;
      menu_pend <= menu_pend_nxt;
      play_pend <= play_pend_nxt;
      color_out <= disp_ena ? pix_sel : '0;
    end
  end

  always_comb begin
    screen_state = state;
    for (int unsigned i = 0; i < N_MODES; i++)
      mode_active[i] = (state == PLAY) && (mode_idx == MODE_W'(i));
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// Randomized self-checking bench for screen_sequencer against a frame-level
// behavioural model of the menu/play/result flow.
module tb_screen_sequencer;

  localparam int W    = 12;
  localparam int NM   = 2;
  localparam int HOLD = 3;

  logic           clk25 = 1'b0;
  logic           reset_n = 1'b0;
  logic           disp_ena = 1'b0;
  logic           frame_start = 1'b0;
  logic           menu_req = 1'b0;
  logic [NM-1:0]  play_req = '0;
  logic [2*NM-1:0] result_code = '0;
  logic [W-1:0]   menu_pix = '0;
  logic [NM*W-1:0] game_pix = '0;
  logic [3*W-1:0] result_pix = '0;
  logic [W-1:0]   color_out;
  logic [NM-1:0]  mode_active;
  logic [1:0]     screen_state;

  int n_pass = 0;
  int n_total = 0;

  // model: screen 0 menu, 1 play, 2 result
  int        m_scr, m_mode, m_res, m_frame, m_entry;
  logic      m_menu_p;
  logic [NM-1:0] m_play_p;
  logic [W-1:0]  exp_color;
  logic [1:0]    exp_state;
  logic [NM-1:0] exp_active;

  screen_sequencer #(.COLOR_W(W), .N_MODES(NM), .HOLD_FRAMES(HOLD)) dut (
    .clk25(clk25), .reset_n(reset_n), .disp_ena(disp_ena), .frame_start(frame_start),
    .menu_req(menu_req), .play_req(play_req), .result_code(result_code),
    .menu_pix(menu_pix), .game_pix(game_pix), .result_pix(result_pix),
    .color_out(color_out), .mode_active(mode_active), .screen_state(screen_state)
  );

  always #20 clk25 = ~clk25;

  task automatic model_reset();
    m_scr = 0; m_mode = 0; m_res = 0; m_frame = 0; m_entry = 0;
    m_menu_p = 1'b0; m_play_p = '0;
    exp_color = '0; exp_state = 2'd0; exp_active = '0;
  endtask

  // Advance one clock: model consumes the inputs the DUT samples at this edge.
  task automatic step();
    logic [W-1:0] sel;
    logic         mreq;
    logic [NM-1:0] preq;
    int           rc;
    if (m_scr == 0)      sel = menu_pix;
    else if (m_scr == 1) sel = game_pix[m_mode*W +: W];
    else                 sel = result_pix[(m_res-1)*W +: W];
    exp_color = disp_ena ? sel : '0;
    mreq = m_menu_p | menu_req;
    preq = m_play_p | ((m_scr == 0) ? play_req : '0);
    if (frame_start) begin
      if (m_scr == 0) begin
        if (preq != 0) begin
          m_scr = 1;
          m_mode = 0;
          while (!preq[m_mode]) m_mode++;
        end
      end else if (m_scr == 1) begin
        rc = int'(result_code[2*m_mode +: 2]);
        if (mreq) m_scr = 0;
        else if (rc != 0) begin
          m_scr = 2; m_res = rc; m_entry = m_frame;
        end
      end else begin
        if (mreq) m_scr = 0;
        else if (HOLD > 0 && m_frame - m_entry == HOLD) m_scr = 0;
      end
      m_frame++;
      m_menu_p = 1'b0;
      m_play_p = '0;
    end else begin
      m_menu_p = mreq;
      m_play_p = preq;
    end
    exp_state  = 2'(m_scr);
    exp_active = (m_scr == 1) ? NM'(1 << m_mode) : '0;
    @(posedge clk25);
    #1;
  endtask

  task automatic rand_pix();
    menu_pix   = W'($urandom);
    game_pix   = {W'($urandom), W'($urandom)};
    result_pix = {W'($urandom), W'($urandom), W'($urandom)};
  endtask

  task automatic go_menu();
    menu_req = 1'b1; frame_start = 1'b1; play_req = '0;
    step();
    menu_req = 1'b0; frame_start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    n_total++;
    if (color_out !== '0 || screen_state !== 2'd0 || mode_active !== '0)
      $display("FAIL reset_hold: color=%h state=%0d active=%b required 000/0/00", color_out, screen_state, mode_active);
    else n_pass++;
    @(negedge clk25);
    reset_n = 1'b1;
    model_reset();
    disp_ena = 1'b1;
    menu_pix = 12'hF00;
    step();
    n_total++;
    if (color_out !== 12'hF00 || color_out !== exp_color)
      $display("FAIL reset_menu_pix: color=%h required %h", color_out, 12'hF00);
    else n_pass++;
    n_total++;
    if (screen_state !== 2'd0 || mode_active !== '0)
      $display("FAIL reset_menu_state: state=%0d active=%b required 0/00", screen_state, mode_active);
    else n_pass++;
  endtask

  task automatic test_frame_sync();
    game_pix = {12'h0F0, 12'h00F};
    play_req = 2'b10;
    step();
    play_req = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_total++;
      if (screen_state !== 2'd0 || mode_active !== '0 || color_out !== exp_color)
        $display("FAIL sync_wait: state=%0d active=%b color=%h required 0/00/%h", screen_state, mode_active, color_out, exp_color);
      else n_pass++;
    end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    n_total++;
    if (screen_state !== 2'd1 || mode_active !== 2'b10 || screen_state !== exp_state)
      $display("FAIL sync_start: state=%0d active=%b required 1/10", screen_state, mode_active);
    else n_pass++;
    step();
    n_total++;
    if (color_out !== 12'h0F0)
      $display("FAIL sync_game_pix: color=%h required 0f0", color_out);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    go_menu();
    play_req = 2'b11; frame_start = 1'b1;
    step();
    play_req = '0; frame_start = 1'b0;
    n_total++;
    if (screen_state !== 2'd1 || mode_active !== 2'b01 || mode_active !== exp_active)
      $display("FAIL simul_lowest: state=%0d active=%b required 1/01", screen_state, mode_active);
    else n_pass++;
  endtask

  task automatic test_result();
    logic [3*W-1:0] rp;
    go_menu();
    play_req = 2'b01; frame_start = 1'b1;
    step();
    play_req = '0; frame_start = 1'b0;
    rp = result_pix;
    result_code = {2'($urandom_range(1, 3)), 2'd2};
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (screen_state !== 2'd1)
        $display("FAIL result_wait: state=%0d required 1", screen_state);
      else n_pass++;
    end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    n_total++;
    if (screen_state !== 2'd2 || mode_active !== '0)
      $display("FAIL result_enter: state=%0d active=%b required 2/00", screen_state, mode_active);
    else n_pass++;
    for (int f = 1; f <= HOLD; f++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        n_total++;
        if (color_out !== rp[W +: W] || screen_state !== 2'd2 || color_out !== exp_color)
          $display("FAIL result_hold f%0d: color=%h state=%0d required %h/2", f, color_out, screen_state, rp[W +: W]);
        else n_pass++;
      end
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      n_total++;
      if (screen_state !== ((f == HOLD) ? 2'd0 : 2'd2) || screen_state !== exp_state)
        $display("FAIL result_frame f%0d: state=%0d required %0d", f, screen_state, (f == HOLD) ? 0 : 2);
      else n_pass++;
    end
    step();
    n_total++;
    if (color_out !== menu_pix || color_out !== exp_color)
      $display("FAIL result_return: color=%h required %h", color_out, menu_pix);
    else n_pass++;
    result_code = '0;
  endtask

  task automatic test_menu_priority();
    go_menu();
    play_req = 2'b10; frame_start = 1'b1;
    step();
    play_req = '0; frame_start = 1'b0;
    step();
    result_code = 4'b0100;
    menu_req = 1'b1; frame_start = 1'b1;
    step();
    menu_req = 1'b0; frame_start = 1'b0;
    n_total++;
    if (screen_state !== 2'd0 || mode_active !== '0 || screen_state !== exp_state)
      $display("FAIL menu_priority: state=%0d active=%b required 0/00", screen_state, mode_active);
    else n_pass++;
    result_code = '0;
  endtask

  task automatic test_blank_async_reset();
    logic [3*W-1:0] rp;
    go_menu();
    play_req = 2'b10; frame_start = 1'b1;
    step();
    play_req = '0;
    result_code = 4'b1100;
    step();
    frame_start = 1'b0;
    rp = result_pix;
    disp_ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_total++;
      if (color_out !== '0 || screen_state !== 2'd2)
        $display("FAIL blank_result: color=%h state=%0d required 000/2", color_out, screen_state);
      else n_pass++;
    end
    disp_ena = 1'b1;
    step();
    n_total++;
    if (color_out !== rp[2*W +: W])
      $display("FAIL result3_pix: color=%h required %h", color_out, rp[2*W +: W]);
    else n_pass++;
    #5;
    reset_n = 1'b0;
    #1;
    n_total++;
    if (color_out !== '0 || screen_state !== 2'd0 || mode_active !== '0)
      $display("FAIL async_reset: color=%h state=%0d active=%b required 000/0/00", color_out, screen_state, mode_active);
    else n_pass++;
    @(negedge clk25);
    reset_n = 1'b1;
    result_code = '0;
    model_reset();
    step();
    n_total++;
    if (color_out !== menu_pix || screen_state !== 2'd0)
      $display("FAIL after_reset: color=%h state=%0d required %h/0", color_out, screen_state, menu_pix);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rand_pix();
      disp_ena    = ($urandom_range(0, 9) != 0);
      frame_start = (cyc % 9 == 8);
      menu_req    = ($urandom_range(0, 39) == 0);
      play_req    = ($urandom_range(0, 11) == 0) ? NM'($urandom) : '0;
      if (cyc % 45 == 0)
        result_code = ($urandom_range(0, 1) == 0) ? '0 : 4'($urandom);
      step();
      n_total++;
      if (color_out !== exp_color || screen_state !== exp_state || mode_active !== exp_active)
        $display("FAIL random c%0d: color=%h state=%0d active=%b required %h/%0d/%b",
                 cyc, color_out, screen_state, mode_active, exp_color, exp_state, exp_active);
      else n_pass++;
    end
    frame_start = 1'b0; menu_req = 1'b0; play_req = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_frame_sync();
    test_simultaneous();
    test_result();
    test_menu_priority();
    test_blank_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
